// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin burst arbiter.
// The FSM encoding is fixed so the debug state output decodes the same everywhere.
package rr_arb_pkg;

    localparam int DEFAULT_NUM_CH = 4;
    localparam int DEFAULT_SIZE_W = 3;
    localparam int ID_W           = $clog2(DEFAULT_NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arbStateT;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester found scanning
// ptr, ptr+1, ... with wrap-around wins.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int PICK_W = $clog2(DEFAULT_NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PICK_W-1:0] ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PICK_W-1:0] grantIdx,
    output logic              valid
);

    int                cand;
    logic [PICK_W-1:0] candIdx;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        valid    = 1'b0;
        cand     = 0;
        candIdx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Modulo by subtraction keeps this valid for non-power-of-two channel counts.
            cand = int'(ptr) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            candIdx = PICK_W'(cand);
            if (!valid && req[candIdx]) begin
                valid          = 1'b1;
                grant[candIdx] = 1'b1;
                grantIdx       = candIdx;
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-channel round-robin arbiter: grants one channel for a latched burst of
// done beats, then re-arbitrates with the finished channel at lowest priority.
module rr_burst_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH,
    parameter int SIZE_W = DEFAULT_SIZE_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH*SIZE_W-1:0]   size,
    input  logic                       done,
    output logic [NUM_CH-1:0]          resp,
    output logic                       start,
    output logic                       busy,
    output logic [$clog2(NUM_CH)-1:0]  grant_id,
    output logic [1:0]                 dbgState
);

    localparam int idW = $clog2(NUM_CH);

    // Handshake: req is a level sampled only in IDLE; once granted, resp stays
    // high until the done beats (one per cycle with done=1, XFER only) reach
    // the latched size. Dropping req or changing size mid-burst has no effect.

    arbStateT            state, stateNext;
    logic [idW-1:0]      ptr, ptrNext;
    logic [idW-1:0]      gIdx, gIdxNext;
    logic [NUM_CH-1:0]   gMask, gMaskNext;
    logic [SIZE_W-1:0]   cnt, cntNext;
    logic [SIZE_W-1:0]   effSize, effSizeNext;
    logic [NUM_CH-1:0]   respNext;
    logic                startNext, busyNext;

    logic [NUM_CH-1:0]   pickGrant;
    logic [idW-1:0]      pickIdx;
    logic                pickValid;
    logic [SIZE_W-1:0]   pickSize;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .PICK_W (idW)
    ) u_pick (
        .req      (req),
        .ptr      (ptr),
        .grant    (pickGrant),
        .grantIdx (pickIdx),
        .valid    (pickValid)
    );

    always_comb begin
        pickSize = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pickIdx == idW'(i)) begin
                pickSize = size[i*SIZE_W +: SIZE_W];
            end
        end
    end

    always_comb begin
        stateNext   = state;
        ptrNext     = ptr;
        gIdxNext    = gIdx;
        gMaskNext   = gMask;
        cntNext     = cnt;
        effSizeNext = effSize;
        case (state)
            IDLE: begin
                if (pickValid) begin
                    stateNext   = GRANT;
                    gIdxNext    = pickIdx;
                    gMaskNext   = pickGrant;
                    // A zero-length request still moves one beat.
                    effSizeNext = (pickSize == '0) ? SIZE_W'(1) : pickSize;
                end
            end
            GRANT: begin
                stateNext = XFER;
                cntNext   = '0;
            end
            XFER: begin
                if (done) begin
                    cntNext = cnt + SIZE_W'(1);
                    if (cntNext == effSize) begin
                        stateNext = IDLE;
                        ptrNext   = (gIdx == idW'(NUM_CH - 1)) ? '0 : gIdx + idW'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        busyNext  = (stateNext != IDLE);
        startNext = (stateNext == GRANT);
        respNext  = busyNext ? gMaskNext : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            gIdx     <= '0;
            gMask    <= '0;
            cnt      <= '0;
            effSize  <= '0;
            resp     <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            state    <= stateNext;
            ptr      <= ptrNext;
            gIdx     <= gIdxNext;
            gMask    <= gMaskNext;
            cnt      <= cntNext;
            effSize  <= effSizeNext;
            resp     <= respNext;
            start    <= startNext;
            busy     <= busyNext;
            grant_id <= gIdxNext;
        end
    end

    assign dbgState = state;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: cycle-by-cycle vector table plus
// hand-written sequences for sparse done beats and mid-burst async reset.
module tb_rr_burst_arbiter;
    import rr_arb_pkg::*;

    logic              clk;
    logic              reset;
    logic [3:0]        req;
    logic [11:0]       size;
    logic              done;
    logic [3:0]        resp;
    logic              start;
    logic              busy;
    logic [ID_W-1:0]   grantId;
    logic [1:0]        dbgState;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [11:0] size;
        logic        done;
        logic [3:0]  eResp;
        logic        eStart;
        logic        eBusy;
        logic [1:0]  eId;
    } vecT;

    vecT        vecs[64];
    int         nVec = 0;
    logic [7:0] expQ[$];

    rr_burst_arbiter #(
        .NUM_CH (4),
        .SIZE_W (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .size     (size),
        .done     (done),
        .resp     (resp),
        .start    (start),
        .busy     (busy),
        .grant_id (grantId),
        .dbgState (dbgState)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] sz(int s3, int s2, int s1, int s0);
        return {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    task automatic addVec(logic r, logic [3:0] rq, logic [11:0] s, logic d,
                          logic [3:0] eResp, logic eStart, logic eBusy, logic [1:0] eId);
        vecs[nVec] = '{r, rq, s, d, eResp, eStart, eBusy, eId};
        nVec++;
    endtask

    // Apply inputs for one cycle, then sample just after the rising edge.
    task automatic driveCycle(logic r, logic [3:0] rq, logic [11:0] s, logic d);
        reset = r;
        req   = rq;
        size  = s;
        done  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [7:0] expV);
        logic [7:0] got;
        got = {resp, start, busy, grantId};
        checks++;
        if (got !== expV) begin
            errors++;
            $display("FAIL %s: got resp=%b start=%b busy=%b id=%0d, expected resp=%b start=%b busy=%b id=%0d",
                     tag, got[7:4], got[3], got[2], got[1:0], expV[7:4], expV[3], expV[2], expV[1:0]);
        end
    endtask

    initial begin
        int         beats;
        logic [11:0] pat;
        logic        d;

        reset = 1'b0;
        req   = '0;
        size  = '0;
        done  = 1'b0;

        // Reset held with every channel requesting, then release: ch0 first.
        addVec(0, 4'b1111, sz(1,1,1,1), 0, 4'b0000, 0, 0, 2'd0);
        addVec(0, 4'b1111, sz(1,1,1,1), 0, 4'b0000, 0, 0, 2'd0);
        addVec(1, 4'b1111, sz(1,1,1,1), 0, 4'b0001, 1, 1, 2'd0);
        // Single channel, size 1, done held high; done in GRANT/IDLE ignored.
        addVec(1, 4'b0001, sz(1,1,1,1), 1, 4'b0001, 0, 1, 2'd0);
        addVec(1, 4'b0001, sz(1,1,1,1), 1, 4'b0000, 0, 0, 2'd0);
        addVec(1, 4'b0001, sz(1,1,1,1), 1, 4'b0001, 1, 1, 2'd0);
        addVec(1, 4'b0001, sz(1,1,1,1), 1, 4'b0001, 0, 1, 2'd0);
        addVec(1, 4'b0001, sz(1,1,1,1), 1, 4'b0000, 0, 0, 2'd0);
        // ch0 size 4 and ch2 size 2 competing from ptr=0.
        addVec(0, 4'b0101, sz(1,2,1,4), 1, 4'b0000, 0, 0, 2'd0);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0001, 1, 1, 2'd0);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0001, 0, 1, 2'd0);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0001, 0, 1, 2'd0);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0001, 0, 1, 2'd0);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0001, 0, 1, 2'd0);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0000, 0, 0, 2'd0);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0100, 1, 1, 2'd2);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0100, 0, 1, 2'd2);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0100, 0, 1, 2'd2);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0000, 0, 0, 2'd2);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0001, 1, 1, 2'd0);
        addVec(1, 4'b0101, sz(1,2,1,4), 1, 4'b0001, 0, 1, 2'd0);
        // All requesting, size 1 each: rotation 0,1,2,3,0.
        addVec(0, 4'b1111, sz(1,1,1,1), 1, 4'b0000, 0, 0, 2'd0);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0001, 1, 1, 2'd0);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0001, 0, 1, 2'd0);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0000, 0, 0, 2'd0);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0010, 1, 1, 2'd1);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0010, 0, 1, 2'd1);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0000, 0, 0, 2'd1);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0100, 1, 1, 2'd2);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0100, 0, 1, 2'd2);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0000, 0, 0, 2'd2);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b1000, 1, 1, 2'd3);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b1000, 0, 1, 2'd3);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0000, 0, 0, 2'd3);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0001, 1, 1, 2'd0);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0001, 0, 1, 2'd0);
        addVec(1, 4'b1111, sz(1,1,1,1), 1, 4'b0000, 0, 0, 2'd0);
        // Size 0 behaves as a single beat.
        addVec(1, 4'b0010, sz(0,0,0,0), 1, 4'b0010, 1, 1, 2'd1);
        addVec(1, 4'b0010, sz(0,0,0,0), 1, 4'b0010, 0, 1, 2'd1);
        addVec(1, 4'b0010, sz(0,0,0,0), 1, 4'b0000, 0, 0, 2'd1);

        for (int i = 0; i < nVec; i++) begin
            driveCycle(vecs[i].rst, vecs[i].req, vecs[i].size, vecs[i].done);
            check($sformatf("vec%0d", i),
                  {vecs[i].eResp, vecs[i].eStart, vecs[i].eBusy, vecs[i].eId});
        end

        // ch1 size 5, req dropped, sparse done: held until the fifth beat (ptr=2 here).
        driveCycle(1, 4'b0010, sz(0,0,5,0), 0);
        check("t5_grant", {4'b0010, 1'b1, 1'b1, 2'd1});
        driveCycle(1, 4'b0000, sz(0,0,0,0), 1);
        check("t5_grant_done_ignored", {4'b0010, 1'b0, 1'b1, 2'd1});
        beats = 0;
        pat   = 12'b1001_0011_0010;
        for (int i = 0; i < 12; i++) begin
            d = pat[i];
            if (beats < 5 && d) beats++;
            expQ.push_back((beats < 5) ? {4'b0010, 1'b0, 1'b1, 2'd1}
                                       : {4'b0000, 1'b0, 1'b0, 2'd1});
            driveCycle(1, 4'b0000, sz(0,0,0,0), d);
            check($sformatf("t5_beat%0d", i), expQ.pop_front());
        end

        // ch3 size 4 aborted by async reset after two beats (ptr=2 here).
        driveCycle(1, 4'b1000, sz(4,0,0,0), 0);
        check("t6_grant", {4'b1000, 1'b1, 1'b1, 2'd3});
        driveCycle(1, 4'b1000, sz(4,0,0,0), 0);
        check("t6_xfer", {4'b1000, 1'b0, 1'b1, 2'd3});
        driveCycle(1, 4'b1000, sz(4,0,0,0), 1);
        check("t6_beat1", {4'b1000, 1'b0, 1'b1, 2'd3});
        driveCycle(1, 4'b1000, sz(4,0,0,0), 1);
        check("t6_beat2", {4'b1000, 1'b0, 1'b1, 2'd3});
        reset = 1'b0;
        req   = 4'b1111;
        #1;
        check("t6_async_reset", 8'h00);
        checks++;
        if (dbgState !== 2'd0) begin
            errors++;
            $display("FAIL t6_state_idle: got state=%0d, expected state=0", dbgState);
        end
        @(posedge clk);
        #1;
        check("t6_reset_held", 8'h00);
        driveCycle(1, 4'b1111, sz(1,1,1,1), 0);
        check("t6_ptr0_after_reset", {4'b0001, 1'b1, 1'b1, 2'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
